// File: rtl/sram_pkg.sv
// Shared types and constants for the parametrised single-port bit-write SRAM.
package sram_pkg;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam int SRAM_DW = 128;
    localparam int SRAM_AW = 6;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then raises ready.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int AW        = SRAM_AW,
    parameter int INIT_ZERO = 1
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          init_we,
    output logic [AW-1:0] init_addr,
    output logic          ready
);

    localparam int            DEPTH    = depth_of(AW);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;

    // ready is registered from the next state so it rises the cycle after the last fill write
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= (INIT_ZERO != 0) ? S_INIT : S_RUN;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= (state_next == S_RUN);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_we    = 1'b0;
        case (state)
            S_INIT: begin
                init_we  = 1'b1;
                cnt_next = cnt + AW'(1);
                if (cnt == CNT_LAST) begin
                    state_next = S_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    assign init_addr = cnt;

endmodule

// File: rtl/sram_1p_bw_sync.sv
// Single-port SRAM with active-low bit-write mask, registered read path and
// an optional second output stage; Q holds the last read value.
module sram_1p_bw_sync
    import sram_pkg::*;
#(
    parameter int DW        = SRAM_DW,
    parameter int AW        = SRAM_AW,
    parameter int OUT_REG   = 0,
    parameter int INIT_ZERO = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CEN,
    input  logic          WEN,
    input  logic [DW-1:0] BWEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          QVALID,
    output logic          READY
);

    localparam int DEPTH = depth_of(AW);

    logic [DW-1:0] ram [DEPTH];

    logic          init_we;
    logic [AW-1:0] init_addr;
    logic          ready;

    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] wr_keep;

    logic [DW-1:0] s1_data;
    logic          s1_valid;

    sram_init_seq #(
        .AW        (AW),
        .INIT_ZERO (INIT_ZERO)
    ) u_init_seq (
        .CLK       (CLK),
        .RST       (RST),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    // Until ready, the sweep owns the write port and user accesses are dropped.
    // Nothing touches the array on a reset edge.
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = A;
        wr_data = D;
        wr_keep = BWEN;
        if (!RST) begin
            if (ready) begin
                wr_en = !CEN && !WEN;
                rd_en = !CEN && WEN;
            end else begin
                wr_en   = init_we;
                wr_addr = init_addr;
                wr_data = '0;
                wr_keep = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            ram[wr_addr] <= (wr_data & ~wr_keep) | (ram[wr_addr] & wr_keep);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_data <= ram[A];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] s2_data;
            logic          s2_valid;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign Q      = s2_data;
            assign QVALID = s2_valid;
        end else begin : g_no_out_reg
            assign Q      = s1_data;
            assign QVALID = s1_valid;
        end
    endgenerate

    assign READY = ready;

endmodule
